// File: rtl/perf_counter_bank.sv
// Multi-channel performance monitor: live counters for total/active/idle/paused/event cycles,
// latched into a CSR-readable bank on done, timeout or snapshot.
module perf_counter_bank #(
    parameter int  COUNTER_WIDTH = 32,
    parameter int  NUM_EVENTS    = 4,
    parameter bit  SATURATE      = 1'b1,
    localparam int NUM_CH        = 4 + NUM_EVENTS,
    localparam int SEL_W         = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_pulse,
    input  logic                     done_pulse,
    input  logic                     snap_req,
    input  logic                     pause,
    input  logic                     busy_signal,
    input  logic [NUM_EVENTS-1:0]    event_in,
    input  logic [COUNTER_WIDTH-1:0] timeout_cycles,
    input  logic [SEL_W-1:0]         rd_sel,
    output logic [COUNTER_WIDTH-1:0] rd_data,
    output logic [NUM_CH-1:0]        ovf_flags,
    output logic                     measuring,
    output logic                     measurement_done,
    output logic                     snap_valid,
    output logic                     timed_out
);
    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t state, state_next;

    logic [COUNTER_WIDTH-1:0] live_cnt [NUM_CH];
    logic [COUNTER_WIDTH-1:0] cnt_next [NUM_CH];
    logic [COUNTER_WIDTH-1:0] bank     [NUM_CH];
    logic [NUM_CH-1:0]        live_ovf;
    logic [NUM_CH-1:0]        ovf_next;
    logic [NUM_CH-1:0]        inc;
    logic                     run;
    logic                     timeout_hit;
    logic                     end_meas;
    logic                     snap;
    logic                     clear_live;

    assign run = (state == S_RUN);

    // Channel map: 0 total, 1 active, 2 idle, 3 paused, 4+k event k.
    always_comb begin
        inc    = '0;
        inc[0] = 1'b1;
        inc[1] = !pause && busy_signal;
        inc[2] = !pause && !busy_signal;
        inc[3] = pause;
        for (int k = 0; k < NUM_EVENTS; k++) begin
            inc[4+k] = event_in[k] && !pause;
        end
    end

    always_comb begin
        ovf_next = live_ovf;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_next[i] = live_cnt[i];
            if (inc[i]) begin
                if (&live_cnt[i]) begin
                    ovf_next[i] = 1'b1;
                    cnt_next[i] = SATURATE ? live_cnt[i] : '0;
                end else begin
                    cnt_next[i] = live_cnt[i] + COUNTER_WIDTH'(1);
                end
            end
        end
    end

    // Timeout compares against the post-increment total so total==timeout_cycles at the latch.
    assign timeout_hit = (timeout_cycles != '0) && (cnt_next[0] == timeout_cycles);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start_pulse) state_next = S_RUN;
            S_RUN:   if (done_pulse || timeout_hit) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Ending a measurement outranks both a coincident snapshot and a coincident restart.
    always_comb begin
        measuring  = run;
        end_meas   = run && (done_pulse || timeout_hit);
        snap       = run && snap_req && !end_meas;
        clear_live = start_pulse && !end_meas;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) live_cnt[i] <= '0;
            live_ovf <= '0;
        end else if (clear_live) begin
            for (int i = 0; i < NUM_CH; i++) live_cnt[i] <= '0;
            live_ovf <= '0;
        end else if (run) begin
            for (int i = 0; i < NUM_CH; i++) live_cnt[i] <= cnt_next[i];
            live_ovf <= ovf_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) bank[i] <= '0;
            ovf_flags        <= '0;
            measurement_done <= 1'b0;
            snap_valid       <= 1'b0;
            timed_out        <= 1'b0;
        end else begin
            measurement_done <= end_meas;
            snap_valid       <= snap;
            if (end_meas || snap) begin
                for (int i = 0; i < NUM_CH; i++) bank[i] <= cnt_next[i];
                ovf_flags <= ovf_next;
            end
            if (clear_live) begin
                timed_out <= 1'b0;
            end else if (end_meas && timeout_hit) begin
                timed_out <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel == SEL_W'(i)) rd_data = bank[i];
        end
    end

endmodule
